// File: rtl/alu_operand_seq_pkg.sv
// Shared types and constants for the alu_operand_seq command sequencer.
package alu_operand_seq_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREG  = 4;
  localparam int unsigned AW    = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // One ALU command as presented on the command handshake
  typedef struct packed {
    logic [1:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rt;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/alu_operand_seq_if.sv
// Command, alu and result signals of alu_operand_seq.
// ALU_ZERO_FLAG_EN adds the res_zero result flag.
interface alu_operand_seq_if;
  import alu_operand_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_rd;
  logic [AW-1:0]    cmd_rs;
  logic [AW-1:0]    cmd_rt;
  logic             cmd_use_imm;
  logic [WIDTH-1:0] cmd_imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [AW-1:0]    res_rd;
`ifdef ALU_ZERO_FLAG_EN
  logic             res_zero;
`endif

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_c,
    output res_valid, res_data, res_rd,
`ifdef ALU_ZERO_FLAG_EN
    output res_zero,
`endif
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_c,
    input  res_valid, res_data, res_rd,
`ifdef ALU_ZERO_FLAG_EN
    input  res_zero,
`endif
    output res_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// Operand register file: two async read ports, one sync write port, r0 reads zero.
module alu_regfile
  import alu_operand_seq_pkg::*;
#(
  parameter int unsigned DW = WIDTH,
  parameter int unsigned NR = NREG,
  parameter int unsigned IW = AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] raddr_a,
  input  logic [IW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a_c,
  output logic [DW-1:0] rdata_b_c,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs_q [NR];

  // r0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NR); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a_c = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b_c = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/alu_operand_seq.sv
// Sequencer feeding the external 4-bit alu: operand fetch, result capture, write-back.
// ALU_ZERO_FLAG_EN adds a registered res_zero flag alongside res_data.
module alu_operand_seq
  import alu_operand_seq_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  alu_operand_seq_if.slave bus
);

  state_e           state_q, state_d;
  cmd_t             cmd_c;
  logic [WIDTH-1:0] rs_data_c, rt_data_c;
  logic             we_c;

  logic             cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [AW-1:0]    res_rd_q, res_rd_d;
`ifdef ALU_ZERO_FLAG_EN
  logic             res_zero_q, res_zero_d;
`endif

  assign cmd_c = '{op:      bus.cmd_op,
                   rd:      bus.cmd_rd,
                   rs:      bus.cmd_rs,
                   rt:      bus.cmd_rt,
                   use_imm: bus.cmd_use_imm,
                   imm:     bus.cmd_imm};

  alu_regfile #(
    .DW (WIDTH),
    .NR (NREG),
    .IW (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a   (cmd_c.rs),
    .raddr_b   (cmd_c.rt),
    .rdata_a_c (rs_data_c),
    .rdata_b_c (rt_data_c),
    .we        (we_c),
    .waddr     (rd_q),
    .wdata     (bus.alu_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless its state updates it
  always_comb begin
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
`ifdef ALU_ZERO_FLAG_EN
    res_zero_d  = res_zero_q;
`endif
    we_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d  = rs_data_c;
          alu_b_d  = cmd_c.use_imm ? cmd_c.imm : rt_data_c;
          alu_op_d = cmd_c.op;
          rd_d     = cmd_c.rd;
        end
      end
      EXEC: begin
        res_valid_d = 1'b1;
        res_data_d  = bus.alu_c;
        res_rd_d    = rd_q;
`ifdef ALU_ZERO_FLAG_EN
        res_zero_d  = (bus.alu_c == '0);
`endif
        we_c        = 1'b1;
      end
      RESP: begin
        if (bus.res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
    // Ready depends only on the upcoming state, so res_ready reaches it through a flop
    cmd_ready_d = (state_d == IDLE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      rd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      cmd_ready_q <= cmd_ready_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_q  <= res_zero_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
`ifdef ALU_ZERO_FLAG_EN
  assign bus.res_zero  = res_zero_q;
`endif

endmodule
